// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (IF) and MEM-stage ports onto one shared memory bus.
// Define ARB_ROUND_ROBIN_EN to hand ties to the port that was not the last owner; default: MEM wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IReq,
  input  logic [ADDR_W-1:0]   IAddr,
  output logic [DATA_W-1:0]   IRData,
  output logic                IAck,
  input  logic                DReq,
  input  logic                DWe,
  input  logic [ADDR_W-1:0]   DAddr,
  input  logic [DATA_W-1:0]   DWData,
  input  logic [DATA_W/8-1:0] DByteEn,
  output logic [DATA_W-1:0]   DRData,
  output logic                DAck,
  output logic                BusReq,
  output logic                BusWe,
  output logic [ADDR_W-1:0]   BusAddr,
  output logic [DATA_W-1:0]   BusWData,
  output logic [DATA_W/8-1:0] BusByteEn,
  input  logic [DATA_W-1:0]   BusRData,
  input  logic                BusReady,
  output logic                StallFetch,
  output logic                StallMem,
  output logic                BusErr,
  output logic [1:0]          Grant
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10} state_t;

  state_t            state;
  logic [7:0]        wait_cnt;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;
  logic              i_elig;
  logic              d_elig;
  logic              pick_d;

  // Handshake: xReq is a level held by the requester until its xAck, a one-cycle completion pulse;
  // a bus transfer completes on any granted cycle in which BusReady is 1.
  assign i_elig = IReq && !IAck;
  assign d_elig = DReq && !DAck;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  assign pick_d = d_elig && (!i_elig || !last_d);
`else
  assign pick_d = d_elig;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      IRData    <= '0;
      DRData    <= '0;
      IAck      <= 1'b0;
      DAck      <= 1'b0;
      BusErr    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= 1'b0;
`endif
    end else begin
      IAck   <= 1'b0;
      DAck   <= 1'b0;
      BusErr <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            state     <= GNT_D;
            wait_cnt  <= '0;
            cap_we    <= DWe;
            cap_addr  <= DAddr;
            cap_wdata <= DWData;
            cap_be    <= DByteEn;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b1;
`endif
          end else if (i_elig) begin
            state     <= GNT_I;
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= IAddr;
            cap_wdata <= '0;
            cap_be    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
          end
        end
        GNT_I, GNT_D: begin
          if (BusReady) begin
            state <= IDLE;
            if (state == GNT_I) begin
              IAck   <= 1'b1;
              IRData <= BusRData;
            end else begin
              DAck <= 1'b1;
              if (!cap_we) DRData <= BusRData;
            end
          end else begin
            // Abort on the edge where the stalled-cycle count reaches TIMEOUT.
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == TMO) begin
              state  <= IDLE;
              BusErr <= 1'b1;
              if (state == GNT_I) IAck <= 1'b1;
              else                DAck <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BusReq     = (state != IDLE);
  assign BusWe      = BusReq & cap_we;
  assign BusAddr    = BusReq ? cap_addr  : '0;
  assign BusWData   = BusReq ? cap_wdata : '0;
  assign BusByteEn  = BusReq ? cap_be    : '0;
  assign Grant      = state;
  assign StallFetch = IReq & ~IAck;
  assign StallMem   = DReq & ~DAck;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; honours ARB_ROUND_ROBIN_EN for the tie-break expectation.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int T  = 4;

  logic          CLK;
  logic          RST;
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic [DW-1:0] IRData;
  logic          IAck;
  logic          DReq;
  logic          DWe;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWData;
  logic [BW-1:0] DByteEn;
  logic [DW-1:0] DRData;
  logic          DAck;
  logic          BusReq;
  logic          BusWe;
  logic [AW-1:0] BusAddr;
  logic [DW-1:0] BusWData;
  logic [BW-1:0] BusByteEn;
  logic [DW-1:0] BusRData;
  logic          BusReady;
  logic          StallFetch;
  logic          StallMem;
  logic          BusErr;
  logic [1:0]    Grant;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_irdata;
  logic [DW-1:0] exp_drdata;
  bit            model_last_d;
  logic [1:0]    exp_q[$];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .CLK(CLK), .RST(RST),
    .IReq(IReq), .IAddr(IAddr), .IRData(IRData), .IAck(IAck),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DByteEn(DByteEn),
    .DRData(DRData), .DAck(DAck),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWData(BusWData),
    .BusByteEn(BusByteEn), .BusRData(BusRData), .BusReady(BusReady),
    .StallFetch(StallFetch), .StallMem(StallMem), .BusErr(BusErr), .Grant(Grant)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    IReq = 0; IAddr = '0; DReq = 0; DWe = 0; DAddr = '0; DWData = '0; DByteEn = '0;
    BusRData = '0; BusReady = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({BusReq, Grant, IAck, DAck, BusErr, StallFetch, StallMem} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 00000000", {BusReq, Grant, IAck, DAck, BusErr, StallFetch, StallMem});
    end
    checks++;
    if ({IRData, DRData} !== {2*DW{1'b0}}) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h exp 0/0", IRData, DRData);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BusReq, Grant, BusWe, BusAddr} !== {4'b0, {AW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_idle got req %b grant %b addr %h exp 0 00 0", BusReq, Grant, BusAddr);
    end
    exp_irdata = '0;
    exp_drdata = '0;
    model_last_d = 1'b0;
  endtask

  // One transaction from an idle arbiter: grant at cycle 1, ready after delay stalled cycles,
  // abort with BusErr once T granted cycles pass without ready.
  task automatic do_txn(input string name, input bit port, input bit we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [BW-1:0] be, input logic [DW-1:0] rdata,
                        input int delay, input bit drop);
    int                last;
    bit                tmo, req, ack, exp_busreq, mask;
    logic [7:0]        exp_ctl, got_ctl;
    logic [AW+DW+BW:0] exp_bus, got_bus;
    tmo  = (delay >= T);
    last = tmo ? T : delay + 1;
    for (int k = 0; k <= last + 2; k++) begin
      @(posedge CLK); #1;
      req  = (k <= last + 1) && !(drop && k >= 1);
      IReq = port ? 1'b0 : req;
      DReq = port ? req : 1'b0;
      if (k == 0) begin
        IAddr = addr; DAddr = addr; DWe = we; DWData = wdata; DByteEn = be;
      end else begin
        IAddr = $urandom; DAddr = $urandom; DWe = 1'($urandom); DWData = $urandom;
        DByteEn = BW'($urandom);
      end
      BusReady = (k >= 1) && (k - 1 == delay);
      BusRData = BusReady ? rdata : $urandom;
      @(negedge CLK);
      ack = (k == last + 1);
      if (ack && !tmo) begin
        if (!port) exp_irdata = rdata;
        else if (!we) exp_drdata = rdata;
      end
      exp_busreq = (k >= 1) && (k <= last);
      exp_ctl = {exp_busreq, exp_busreq ? (port ? 2'b10 : 2'b01) : 2'b00, ack & !port, ack & port,
                 ack & tmo, IReq & !(ack & !port), DReq & !(ack & port)};
      got_ctl = {BusReq, Grant, IAck, DAck, BusErr, StallFetch, StallMem};
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl k=%0d got %b exp %b", name, k, got_ctl, exp_ctl);
      end
      mask = exp_busreq && !port;
      exp_bus = exp_busreq ? {port & we, addr, port ? wdata : {DW{1'b0}}, port ? be : {BW{1'b0}}}
                           : {(AW+DW+BW+1){1'b0}};
      got_bus = {BusWe, BusAddr, mask ? {DW{1'b0}} : BusWData, mask ? {BW{1'b0}} : BusByteEn};
      checks++;
      if (got_bus !== exp_bus) begin
        errors++;
        $display("FAIL %s bus k=%0d got %h exp %h", name, k, got_bus, exp_bus);
      end
      checks++;
      if ({IRData, DRData} !== {exp_irdata, exp_drdata}) begin
        errors++;
        $display("FAIL %s rdata k=%0d got %h/%h exp %h/%h", name, k, IRData, DRData, exp_irdata, exp_drdata);
      end
    end
    model_last_d = port;
  endtask

  task automatic test_if_read();
    do_txn("if_read", 1'b0, 1'b0, 32'h100, '0, '0, 32'hDEADBEEF, 0, 1'b0);
  endtask

  task automatic test_write_wait();
    do_txn("write_wait", 1'b1, 1'b1, 32'h2000, 32'h12345678, 4'hF, 32'hCAFEF00D, 3, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn("timeout", 1'b1, 1'b0, 32'h3000, '0, 4'hF, 32'h55AA55AA, 8, 1'b0);
  endtask

  task automatic test_drop();
    do_txn("drop", 1'b0, 1'b0, 32'h440, '0, '0, 32'h0BADF00D, 2, 1'b1);
  endtask

  // Both ports request together and keep requesting; BusReady held high.
  task automatic test_tie();
    bit            first_d;
    logic [DW-1:0] rd, rd_prev;
    logic [1:0]    exp_g, exp_ack;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = !model_last_d;
`else
    first_d = 1'b1;
`endif
    for (int i = 0; i < 4; i++)
      exp_q.push_back((first_d ^ ((i % 2) == 1)) ? 2'b10 : 2'b01);
    rd_prev = '0;
    for (int c = 0; c <= 9; c++) begin
      @(posedge CLK); #1;
      IReq = (c < 8); DReq = (c < 8); DWe = 1'b0;
      IAddr = $urandom; DAddr = $urandom;
      BusReady = 1'b1;
      rd = $urandom;
      BusRData = rd;
      @(negedge CLK);
      exp_g = (c % 2 == 1 && c <= 7) ? exp_q[0] : 2'b00;
      checks++;
      if (Grant !== exp_g) begin
        errors++;
        $display("FAIL tie grant c=%0d got %b exp %b", c, Grant, exp_g);
      end
      exp_ack = (c % 2 == 0 && c >= 2) ? exp_q.pop_front() : 2'b00;
      if (exp_ack == 2'b01) exp_irdata = rd_prev;
      if (exp_ack == 2'b10) exp_drdata = rd_prev;
      if (exp_ack != 2'b00) model_last_d = exp_ack[1];
      checks++;
      if ({DAck, IAck} !== exp_ack) begin
        errors++;
        $display("FAIL tie ack c=%0d got %b exp %b", c, {DAck, IAck}, exp_ack);
      end
      checks++;
      if ({IRData, DRData} !== {exp_irdata, exp_drdata}) begin
        errors++;
        $display("FAIL tie rdata c=%0d got %h/%h exp %h/%h", c, IRData, DRData, exp_irdata, exp_drdata);
      end
      rd_prev = rd;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    @(posedge CLK); #1;
    IReq = 1'b1; IAddr = $urandom; BusReady = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if ({BusReq, Grant} !== 3'b101) begin
      errors++;
      $display("FAIL rst_mid granted got %b exp 101", {BusReq, Grant});
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({BusReq, Grant, IAck, BusErr, BusAddr} !== {5'b0, {AW{1'b0}}}) begin
      errors++;
      $display("FAIL rst_mid async got req %b grant %b ack %b addr %h exp all 0", BusReq, Grant, IAck, BusAddr);
    end
    exp_irdata = '0;
    exp_drdata = '0;
    model_last_d = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({BusReq, IAck, IRData} !== {2'b0, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL rst_mid held got req %b ack %b rdata %h exp 0 0 0", BusReq, IAck, IRData);
    end
    @(negedge CLK);
    a = $urandom;
    IAddr = a;
    RST = 1'b0;
    @(posedge CLK); #1;
    rd = $urandom;
    BusReady = 1'b1; BusRData = rd;
    @(negedge CLK);
    checks++;
    if ({BusReq, Grant, BusAddr, IAck} !== {3'b101, a, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid restart got req %b grant %b addr %h ack %b exp 1 01 %h 0", BusReq, Grant, BusAddr, IAck, a);
    end
    @(posedge CLK); #1;
    IReq = 1'b0; BusReady = 1'b0;
    @(negedge CLK);
    exp_irdata = rd;
    checks++;
    if ({IAck, BusErr, BusReq, IRData} !== {3'b100, rd}) begin
      errors++;
      $display("FAIL rst_mid ack got ack %b err %b req %b rdata %h exp 1 0 0 %h", IAck, BusErr, BusReq, IRData, rd);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if ({IAck, BusReq, IRData} !== {2'b00, exp_irdata}) begin
      errors++;
      $display("FAIL rst_mid settle got ack %b req %b rdata %h exp 0 0 %h", IAck, BusReq, IRData, exp_irdata);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit port, we, drop;
    int delay;
    for (int n = 0; n < 12; n++) begin
      port  = 1'($urandom);
      we    = port & 1'($urandom);
      delay = $urandom_range(0, 6);
      drop  = ($urandom_range(0, 3) == 0);
      do_txn("random", port, we, $urandom, $urandom, BW'($urandom), $urandom, delay, drop);
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_write_wait();
    test_timeout();
    test_tie();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of the IF, MEM and bus ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; byte-enable width SHALL be DATA_W/8.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum granted cycles without BusReady; legal range 1..255.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 IReq in 1 / IAddr in ADDR_W SHALL be the fetch-stage read request and address.
REQ-007 IRData out DATA_W / IAck out 1 SHALL be the fetch read data and the completion pulse.
REQ-008 DReq, DWe in 1 / DAddr in ADDR_W / DWData in DATA_W / DByteEn in DATA_W/8 SHALL be the MEM-stage request.
REQ-009 DRData out DATA_W / DAck out 1 SHALL be the MEM read data and the completion pulse.
REQ-010 BusReq, BusWe out 1 / BusAddr out ADDR_W / BusWData out DATA_W / BusByteEn out DATA_W/8 SHALL drive the shared memory bus.
REQ-011 BusRData in DATA_W / BusReady in 1 SHALL be the bus read data and the transfer-complete strobe.
REQ-012 StallFetch, StallMem out 1 SHALL be the stall requests to the hazard logic; BusErr out 1 SHALL flag a timeout; Grant out 2 SHALL show the owner (00 none, 01 IF, 10 MEM).

Function
REQ-013 The FSM SHALL have states IDLE, GNT_I and GNT_D.
REQ-014 IDLE: DReq only -> GNT_D; IReq only -> GNT_I; both -> per REQ-026; neither -> stay.
REQ-015 In IDLE, a port whose Ack is high in the current cycle SHALL be excluded from arbitration.
REQ-016 In GNT_x, BusReq SHALL be 1 and the bus outputs SHALL be the granted port's fields, captured at the grant edge and held stable until the transaction ends; BusWe SHALL be 0 for IF.
REQ-017 In GNT_x with BusReady=1, the next edge SHALL register BusRData into xRData, pulse xAck high for exactly one cycle, and return to IDLE.
REQ-018 Minimum latency SHALL be: request in IDLE at cycle 0, BusReq at cycle 1, Ack at cycle 2 when BusReady arrives at cycle 1.
REQ-019 xRData SHALL hold its value until the next completion on that port; for a write, DRData SHALL be unchanged.
REQ-020 Bus outputs SHALL be 0 whenever BusReq=0.
REQ-021 StallFetch SHALL equal IReq AND NOT IAck; StallMem SHALL equal DReq AND NOT DAck (combinational).
REQ-022 An 8-bit wait counter SHALL clear on each grant and increment in every granted cycle with BusReady=0.
REQ-023 When the counter reaches TIMEOUT, the next edge SHALL return to IDLE, pulse xAck and BusErr for one cycle, and leave xRData unchanged.
REQ-024 Deassertion of a request while granted SHALL NOT abort the transaction; Ack SHALL still pulse.
REQ-025 Grant SHALL reflect the current state combinationally.

Reset
REQ-026 (arbitration) Without the macro, MEM SHALL win when both ports request; with it, see REQ-031.
REQ-027 RST high SHALL immediately force IDLE and drive BusReq, IAck, DAck, BusErr and Grant to 0, and IRData, DRData and the wait counter to 0.
REQ-028 RST asserted mid-transaction SHALL abandon the transaction with no Ack.
REQ-029 After RST falls, arbitration SHALL begin at the first rising edge.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-031 When the macro is defined, a last-owner flag (reset value IF) SHALL be kept, and on a tie the port that was not the last owner SHALL win; when undefined, the flag SHALL be absent and REQ-026 applies.

Verification
REQ-032 IReq=1, IAddr=0x100, BusReady at first BusReq cycle with BusRData=0xDEADBEEF -> IAck at cycle 2, IRData=0xDEADBEEF, StallFetch=1 on cycles 0-1.
REQ-033 IReq=DReq=1 in the same cycle, BusReady constant 1 -> D served first, then I; with ARB_ROUND_ROBIN_EN, repeated ties SHALL alternate D,I,D,I.
REQ-034 DReq=1, DWe=1, DAddr=0x2000, DWData=0x12345678, DByteEn=0xF, BusReady delayed 3 cycles -> bus fields stable 4 cycles, DAck once, DRData unchanged.
REQ-035 DReq=1, BusReady held 0, TIMEOUT=4 -> DAck and BusErr pulse together after 4 wait cycles, then state IDLE.
REQ-036 RST asserted in GNT_I -> BusReq=0 in the same cycle without a clock edge, no IAck, and a clean restart after release.
